// File: rtl/dm_bus_responder_pkg.sv
// Shared types and constants for the data-memory bus responder.
// The error-reason codes stay internal; only their OR leaves the block as err.
package dm_bus_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Alignment takes priority over range, so a misaligned out-of-range access reports ALIGN.
    function automatic logic [1:0] classify_access(input logic [1:0]        addr_lo,
                                                   input logic [WORD_W-1:0] off,
                                                   input logic [WORD_W-1:0] limit);
        if (addr_lo != 2'b00)
            return ERR_ALIGN;
        else if (off >= limit)
            return ERR_RANGE;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/dm_bus_responder_if.sv
// Req/ack data-memory bus between the CPU datapath (master) and the memory responder (slave).
interface dm_bus_if;
    import dm_bus_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              ack;
    logic [WORD_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);

endinterface

// File: rtl/dm_bus_responder_ram_sp.sv
// Single-port synchronous word RAM with a registered, write-first read port.
module dm_ram_sp
    import dm_bus_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    always_comb begin
        rdata_d = we ? wdata : mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_bus_responder.sv
// Target end of the CPU data-memory req/ack bus: a word memory that answers each
// access after a programmable number of wait states and flags bad addresses.
module dm_bus_responder
    import dm_bus_pkg::*;
#(
    parameter int                DEPTH       = 1024,
    parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    dm_bus_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [1:0]        err_reason_q, err_reason_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] in_off;
    logic [1:0]        in_err;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    always_comb begin
        in_off = bus.addr - BASE_ADDR;
        in_err = classify_access(bus.addr[1:0], in_off, WORD_W'(DEPTH * 4));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        err_reason_d = err_reason_q;
        busy_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    idx_d        = in_off[AW+1:2];
                    we_d         = bus.we;
                    wdata_d      = bus.wdata;
                    err_reason_d = in_err;
                    busy_d       = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = RESP;
            end
            // busy stays up through the IDLE cycle that follows the ack
            RESP: begin
                busy_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            err_reason_q <= ERR_NONE;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            err_reason_q <= err_reason_d;
            busy_q       <= busy_d;
        end
    end

    // In IDLE the RAM sees the live address so a zero-wait read has data ready in RESP.
    always_comb begin
        ram_addr = (state_q == IDLE) ? in_off[AW+1:2] : idx_q;
        ram_we   = (state_q == RESP) && we_q && (err_reason_q == ERR_NONE);
    end

    dm_ram_sp #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.ack   = (state_q == RESP);
    assign bus.err   = (state_q == RESP) && (err_reason_q != ERR_NONE);
    assign bus.rdata = ((state_q == RESP) && !we_q && (err_reason_q == ERR_NONE)) ? ram_rdata : '0;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Directed plus randomized bench for dm_bus_responder: one instance with two wait
// states at base 0, one zero-wait instance at a nonzero base, both against a word-map model.
module tb_dm_bus_responder;

    localparam int          DEPTH2 = 1024;
    localparam logic [31:0] BASE2  = 32'h0000_0000;
    localparam int          WAIT2  = 2;
    localparam int          DEPTH0 = 64;
    localparam logic [31:0] BASE0  = 32'h0000_0100;
    localparam int          WAIT0  = 0;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mem2 [int unsigned];
    logic [31:0] mem0 [int unsigned];

    dm_bus_if b2();
    dm_bus_if b0();

    dm_bus_responder #(.DEPTH(DEPTH2), .BASE_ADDR(BASE2), .WAIT_CYCLES(WAIT2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    dm_bus_responder #(.DEPTH(DEPTH0), .BASE_ADDR(BASE0), .WAIT_CYCLES(WAIT0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
        end else begin
            b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
        end
    endtask

    // Issues one access, returns ack latency counted in cycles after the accept edge
    // (-1 on timeout) and the number of cycles busy was seen high.
    task automatic applyStimulus(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input string tag, output int lat, output logic [31:0] rd,
                                 output logic e, output int bsy);
        bit seen;
        seen = 1'b0; lat = 0; bsy = 0; rd = '0; e = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        @(posedge clk);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (sel ? b0.busy : b2.busy) bsy++;
            if (sel ? b0.ack : b2.ack) begin
                seen = 1'b1;
                rd   = sel ? b0.rdata : b2.rdata;
                e    = sel ? b0.err : b2.err;
                drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        if (!seen) begin
            lat = -1;
            drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(negedge clk);
        checkOutput({tag, "_ackPulse"}, 32'(sel ? b0.ack : b2.ack), 32'd0);
        checkOutput({tag, "_rdataIdle"}, sel ? b0.rdata : b2.rdata, 32'd0);
        if (sel ? b0.busy : b2.busy) bsy++;
        @(negedge clk);
        if (sel ? b0.busy : b2.busy) bsy++;
    endtask

    task automatic runAccess(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input string tag);
        logic [31:0] base, off, expRd, rd;
        int          depthBytes, waits, lat, bsy;
        int unsigned key;
        logic        expErr, e;
        bit          known;
        base       = sel ? BASE0 : BASE2;
        depthBytes = sel ? DEPTH0 * 4 : DEPTH2 * 4;
        waits      = sel ? WAIT0 : WAIT2;
        off        = a - base;
        expErr     = (a % 4 != 0) || (off >= 32'(depthBytes));
        key        = off / 4;
        known      = 1'b1;
        expRd      = '0;
        if (!expErr) begin
            if (w) begin
                if (sel) mem0[key] = d; else mem2[key] = d;
            end else if (sel ? mem0.exists(key) : mem2.exists(key)) begin
                expRd = sel ? mem0[key] : mem2[key];
            end else begin
                known = 1'b0;
            end
        end
        applyStimulus(sel, w, a, d, tag, lat, rd, e, bsy);
        checkOutput({tag, "_lat"}, lat, 32'(waits + 1));
        checkOutput({tag, "_err"}, 32'(e), 32'(expErr));
        checkOutput({tag, "_busy"}, bsy, 32'(waits + 2));
        if (known) checkOutput({tag, "_rdata"}, rd, expRd);
    endtask

    function automatic logic [31:0] randAddr(input logic [31:0] base, input int depthBytes);
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return base + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            1:       return base + 32'(depthBytes) + 4 * $urandom_range(0, 7);
            2:       return base - 32'd4;
            3:       return base + 32'(depthBytes) - 32'd4;
            default: return base + 4 * $urandom_range(0, 15);
        endcase
    endfunction

    initial begin
        logic [31:0] valA, valB;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack", 32'(b2.ack), 32'd0);
        checkOutput("rst_busy", 32'(b2.busy), 32'd0);
        checkOutput("rst_err", 32'(b2.err), 32'd0);
        checkOutput("rst_rdata", b2.rdata, 32'd0);
        checkOutput("rst_ack0", 32'(b0.ack), 32'd0);
        checkOutput("rst_busy0", 32'(b0.busy), 32'd0);
        rst = 1'b0;

        runAccess(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        runAccess(1'b0, 1'b0, 32'h10, 32'h0, "rd10");
        runAccess(1'b0, 1'b1, 32'h13, 32'h1234, "wrMisaligned");
        runAccess(1'b0, 1'b0, 32'h10, 32'h0, "rd10Again");
        runAccess(1'b0, 1'b0, 32'h1000, 32'h0, "rdOutOfRange");
        runAccess(1'b0, 1'b0, 32'hFFC, 32'h0, "rdLastWord");

        valA = $urandom;
        valB = $urandom;
        runAccess(1'b1, 1'b1, BASE0, valA, "zwWrA");
        runAccess(1'b1, 1'b1, BASE0 + 32'd4, valB, "zwWrB");
        runAccess(1'b1, 1'b0, BASE0 - 32'd4, 32'h0, "zwBelowBase");

        // Zero-wait instance with req held high across two reads
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, BASE0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_ack1", 32'(b0.ack), 32'd1);
        checkOutput("b2b_rd1", b0.rdata, valA);
        b0.addr = BASE0 + 32'd4;
        @(negedge clk);
        checkOutput("b2b_gapAck", 32'(b0.ack), 32'd0);
        checkOutput("b2b_gapBusy", 32'(b0.busy), 32'd1);
        @(negedge clk);
        checkOutput("b2b_ack2", 32'(b0.ack), 32'd1);
        checkOutput("b2b_rd2", b0.rdata, valB);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("b2b_after", 32'(b0.ack), 32'd0);

        // Reset during the wait states of a write must drop the write
        runAccess(1'b0, 1'b1, 32'h20, 32'h0, "wr20Zero");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h5555);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midop_busy", 32'(b2.busy), 32'd1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midop_busyAfterRst", 32'(b2.busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("midop_noAck", 32'(b2.ack), 32'd0);
            @(negedge clk);
        end
        runAccess(1'b0, 1'b0, 32'h20, 32'h0, "rd20AfterAbort");

        for (int i = 0; i < 40; i++) begin
            runAccess(1'b0, 1'($urandom_range(0, 1)), randAddr(BASE2, DEPTH2 * 4), $urandom, "rand2");
            runAccess(1'b1, 1'($urandom_range(0, 1)), randAddr(BASE0, DEPTH0 * 4), $urandom, "rand0");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_bus_responder.md
Name: dm_bus_responder

Overview:
- Memory-side responder for the CPU's data-memory accesses. It replaces a zero-latency combinational DM with a req/ack handshaked word memory that inserts programmable wait states.
- The CPU datapath is the initiator. This block is the target end of that interface.
- It lets the multi-cycle control unit be exercised against slow memory, and flags bad addresses.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 2, wait states inserted between request accept and ack (0..15 legal).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  access request, level; initiator holds it until ack.
- we  input  1  1 = write, 0 = read; qualified by req.
- addr  input  32  byte address of access.
- wdata  input  32  write data.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  read data, valid only while ack=1.
- err  output  1  access error, valid only while ack=1.
- busy  output  1  high from accept until the cycle after ack.

Behaviour:
- Reset (rst=1 at rising edge):
  - State goes to IDLE; ack, err, busy = 0; rdata = 0; wait counter = 0.
  - Memory contents are not reset.
  - An in-flight transaction is aborted; its pending write is never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When req=1 is sampled, latch addr, we and wdata, and set busy=1.
  - If WAIT_CYCLES==0, go to RESP. Otherwise load cnt=WAIT_CYCLES and go to WAIT.
  - Input changes after accept are ignored.
- WAIT:
  - cnt decrements by 1 each cycle.
  - When cnt==1, go to RESP.
- RESP (exactly one cycle):
  - ack=1.
  - For a write, the memory is updated at the end of this cycle.
  - For a read, rdata = mem[idx] as captured from the latched address. The array read is issued in the last WAIT cycle, or at accept when WAIT_CYCLES==0.
  - Next state is IDLE; busy drops in the following cycle.
- Latency:
  - Request accepted at edge k; ack high during cycle k+1+WAIT_CYCLES.
  - Back-to-back throughput is one access per WAIT_CYCLES+2 cycles. IDLE always spends at least one cycle, so req held high across ack starts a new access one cycle after ack.
- Address decode:
  - off = addr - BASE_ADDR (32-bit wraparound subtraction).
  - idx = off[31:2].
  - err=1 if addr[1:0]!=0, or if off >= DEPTH*4.
  - When err=1: no memory write, rdata=0, ack still pulses after the normal latency.
- Reads return 0 in rdata on writes and errors. rdata=0 whenever ack=0.
- Read-after-write: a read accepted after a write's ack returns the new data.
- Protocol violation: if req drops before ack, the transaction still completes and ack still pulses. Initiators must not do this.

Decomposition:
- Shared package dm_bus_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - width constants WORD_W=32 and CNT_W=4;
  - the error-reason localparams ERR_NONE, ERR_ALIGN, ERR_RANGE. These are internal, and only the err OR is exported.
- One sub-module, dm_ram_sp:
  - single-port synchronous word RAM;
  - registered read, write-first;
  - parameterised by DEPTH.
- FSM, counter and decode stay in dm_bus_responder.

Test Plan:
- Reset then write: rst for 2 cycles, then write addr=0x10, wdata=0xDEADBEEF, WAIT_CYCLES=2 → ack high exactly 3 cycles after the accept edge, err=0, busy high 4 cycles.
- Read back: read addr=0x10 → ack after 3 cycles with rdata=0xDEADBEEF, err=0. Read of an unwritten word returns whatever was stored (not checked) except after an explicit zero write.
- Misaligned: write addr=0x13, wdata=0x1234 → ack with err=1, rdata=0. A subsequent read of 0x10 still returns 0xDEADBEEF.
- Out of range: DEPTH=1024, read addr=0x1000 → ack with err=1, rdata=0. Read addr=0xFFC → err=0.
- Zero wait: WAIT_CYCLES=0, req held high for two reads of 0x0 and 0x4 → acks in cycles k+1 and k+3, with one IDLE gap between.
- Reset mid-operation: assert rst during WAIT of a write to 0x20 with data 0x5555 → ack never pulses, busy=0. A later read of 0x20 returns the prior value (0 written beforehand), not 0x5555.
